bram_mask_arbiter: RTL and testbench
====================================

// Module: bram_mask_arbiter
// PURPOSE
//   Shares one single-port lane-masked BRAM between two requesters: port A (rasterizer, read/write)
//   and port B (display scan-out, read-only). Arbitrates round-robin, drives the BRAM's active-low
//   enable, write strobe and lane mask, and returns read data tagged to the requester.
//   Sits between raster/scan-out logic and the bram_mask storage instance.
// PARAMETERS
//   ADDR_WIDTH  12  BRAM address width; DEPTH = 2**ADDR_WIDTH
//   DATA_WIDTH  24  BRAM word width
//   MASK_WIDTH  8   bits per write lane; LANES = DATA_WIDTH/MASK_WIDTH (must divide exactly)
// PORTS
//   clk         in   1           single clock, all logic on rising edge
//   rst_n       in   1           asynchronous active-low reset
//   a_valid     in   1           port A request valid
//   a_ready     out  1           port A request accepted this cycle
//   a_we        in   1           port A 1=write, 0=read
//   a_wen       in   LANES       port A lane write enables (ignored on read)
//   a_addr      in   ADDR_WIDTH  port A address
//   a_wdata     in   DATA_WIDTH  port A write data
//   a_rvalid    out  1           port A read data valid (1-cycle pulse)
//   b_valid     in   1           port B read request valid
//   b_ready     out  1           port B request accepted this cycle
//   b_addr      in   ADDR_WIDTH  port B address
//   b_rvalid    out  1           port B read data valid (1-cycle pulse)
//   rdata       out  DATA_WIDTH  read data, shared; qualified by a_rvalid/b_rvalid
//   clr_start   in   1           start full-memory clear (pulse)
//   clr_value   in   DATA_WIDTH  fill value for clear, sampled at clr_start
//   clr_busy    out  1           clear in progress
//   clr_done    out  1           1-cycle pulse after last clear write issued
//   mem_cen     out  1           to BRAM cen, active low
//   mem_gwen    out  1           to BRAM gwen, 1=write, 0=read
//   mem_wen     out  LANES       to BRAM wen lane mask
//   mem_addr    out  ADDR_WIDTH  to BRAM addr
//   mem_din     out  DATA_WIDTH  to BRAM din
//   mem_dout    in   DATA_WIDTH  from BRAM dout (registered in BRAM, 1-cycle latency)
// BEHAVIOUR
//   - Reset: mem_cen=1, mem_gwen=0, mem_wen=0, mem_addr=0, mem_din=0, a_rvalid=b_rvalid=0,
//     rdata=0, clr_busy=0, clr_done=0, rr pointer=A; a_ready=b_ready=0 while rst_n low.
//   - Handshake: transfer on valid&ready; ready is combinational from valid and rr pointer; at most
//     one of a_ready/b_ready high per cycle. Requester holds fields stable until accepted.
//   - Arbitration: only one valid -> grant it. Both valid -> grant rr pointer side; pointer flips to
//     the other side after every grant. No grant -> pointer unchanged.
//   - Issue: accepted request registered onto mem_* at the accepting edge (cen=0, one cycle only);
//     idle cycles drive mem_cen=1, mem_wen=0. Port B always issues gwen=0.
//   - Read return: accept at edge N, BRAM samples at N+1, rdata=mem_dout and matching rvalid
//     registered at N+2 (2-cycle accept-to-rvalid). Fully pipelined: one accept per cycle; no
//     back-pressure on read data. Writes produce no rvalid.
//   - Write with a_wen=0: issued (cen=0, gwen=1), memory unchanged.
//   - Reset mid-operation: in-flight reads dropped, no rvalid emitted, clear aborted.
// CONFIGURATION
//   BRAM_MASK_ARB_CLEAR_EN defined: FSM IDLE->CLEAR->IDLE. In IDLE, clr_start latches clr_value,
//     enters CLEAR; a_ready=b_ready=0 for whole CLEAR; one write per cycle, addr 0..DEPTH-1, all
//     lanes enabled, din=clr_value; clr_busy=1 in CLEAR; after addr DEPTH-1 issued -> IDLE, clr_done
//     pulses. clr_start during CLEAR ignored. Reads accepted before clr_start still return rvalid.
//     clr_start beats any same-cycle request (request not accepted).
//   Not defined: no FSM; clr_start/clr_value ignored; clr_busy=clr_done=0 constant.
// TESTING
//   1 A write addr 5 data 0xABCDEF wen=3'b111, then A read addr 5 -> a_rvalid 2 cycles after accept,
//     rdata=0xABCDEF; b_rvalid stays 0.
//   2 Over 0xABCDEF at addr 5, A write data 0x123456 wen=3'b010 -> A read returns 0xAB34EF.
//   3 a_valid,b_valid held high 8 cycles, reset pointer=A -> grants A,B,A,B..., 4 each, one mem_cen
//     low per cycle.
//   4 B reads back-to-back addr 0..3 -> b_rvalid 4 consecutive cycles, data in address order.
//   5 CLEAR_EN: clr_start, clr_value=0x000000 -> clr_busy 4096 cycles, readies low, clr_done
//     pulse; any read afterwards returns 0. Without macro: clr_busy stays 0, memory unchanged.
//   6 rst_n low 1 cycle after a B accept -> no b_rvalid, all mem_*/outputs at reset values.

Source files
------------

// File: rtl/bram_mask_arbiter_if.sv
// Requester-side bundle for bram_mask_arbiter: rasterizer port A (read/write),
// scan-out port B (read-only) and the shared tagged read-return data.
// The arbiter connects through the slave modport, requesters through master.
interface bram_mask_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 24,
    parameter int MASK_WIDTH = 8
);
    localparam int LANES = DATA_WIDTH / MASK_WIDTH;

    logic                  a_valid;
    logic                  a_ready;
    logic                  a_we;
    logic [LANES-1:0]      a_wen;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_rvalid;
    logic                  b_valid;
    logic                  b_ready;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output a_valid, a_we, a_wen, a_addr, a_wdata, b_valid, b_addr,
        input  a_ready, a_rvalid, b_ready, b_rvalid, rdata
    );

    modport slave (
        input  a_valid, a_we, a_wen, a_addr, a_wdata, b_valid, b_addr,
        output a_ready, a_rvalid, b_ready, b_rvalid, rdata
    );
endinterface

// File: rtl/bram_mask_arbiter.sv
// bram_mask_arbiter: round-robin sharing of one single-port lane-masked BRAM
// between port A (read/write) and port B (read-only). Accepted requests are
// registered onto the BRAM pins; read data returns two cycles after accept,
// tagged by a_rvalid / b_rvalid.
// Optional feature macro: BRAM_MASK_ARB_CLEAR_EN adds a full-memory clear
// engine (clr_start / clr_value / clr_busy / clr_done). Without it the clear
// inputs are ignored and clr_busy / clr_done stay low.
// DATA_WIDTH must be an exact multiple of MASK_WIDTH.
module bram_mask_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 24,
    parameter int MASK_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    bram_mask_arbiter_if.slave               bus,
    input  logic                             clr_start,
    input  logic [DATA_WIDTH-1:0]            clr_value,
    output logic                             clr_busy,
    output logic                             clr_done,
    output logic                             mem_cen,
    output logic                             mem_gwen,
    output logic [DATA_WIDTH/MASK_WIDTH-1:0] mem_wen,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_din,
    input  logic [DATA_WIDTH-1:0]            mem_dout
);
    localparam int LANES = DATA_WIDTH / MASK_WIDTH;

    logic                  rr_b_r;      // 1: B wins the next contested cycle
    logic                  grant_a_s;
    logic                  grant_b_s;
    logic                  block_s;     // clear engine owns the BRAM this cycle
    logic                  clr_issue_s;
    logic [ADDR_WIDTH-1:0] clr_addr_s;
    logic [DATA_WIDTH-1:0] clr_data_s;
    logic                  rd_a_p1_r;
    logic                  rd_b_p1_r;
    logic                  rd_a_p2_r;
    logic                  rd_b_p2_r;
    logic                  a_rvalid_r;
    logic                  b_rvalid_r;
    logic [DATA_WIDTH-1:0] rdata_r;

`ifdef BRAM_MASK_ARB_CLEAR_EN
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    clr_state_t            state_r;
    logic [ADDR_WIDTH-1:0] clr_addr_r;
    logic [DATA_WIDTH-1:0] clr_value_r;

    // Clear FSM: latch fill value on start, sweep every address once, pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            clr_addr_r  <= '0;
            clr_value_r <= '0;
            clr_busy    <= 1'b0;
            clr_done    <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (clr_start) begin
                        state_r     <= ST_CLEAR;
                        clr_value_r <= clr_value;
                        clr_addr_r  <= '0;
                        clr_busy    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_addr_r <= clr_addr_r + ADDR_WIDTH'(1);
                    if (&clr_addr_r) begin
                        state_r  <= ST_IDLE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    clr_busy <= 1'b0;
                end
            endcase
        end
    end

    // A start request in IDLE takes the BRAM away from any same-cycle request.
    assign block_s     = (state_r == ST_CLEAR) || clr_start;
    assign clr_issue_s = (state_r == ST_CLEAR);
    assign clr_addr_s  = clr_addr_r;
    assign clr_data_s  = clr_value_r;
`else
    logic unused_clr_s;

    assign block_s      = 1'b0;
    assign clr_issue_s  = 1'b0;
    assign clr_addr_s   = '0;
    assign clr_data_s   = '0;
    assign clr_busy     = 1'b0;
    assign clr_done     = 1'b0;
    assign unused_clr_s = ^{clr_start, clr_value};
`endif

    // Grant selection: lone requester wins, contested cycle goes to rr pointer side.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (!rst_n || block_s) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else if (bus.a_valid && bus.b_valid) begin
            if (rr_b_r) begin
                grant_b_s = 1'b1;
            end else begin
                grant_a_s = 1'b1;
            end
        end else if (bus.a_valid) begin
            grant_a_s = 1'b1;
        end else if (bus.b_valid) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    assign bus.a_ready  = grant_a_s;
    assign bus.b_ready  = grant_b_s;
    assign bus.a_rvalid = a_rvalid_r;
    assign bus.b_rvalid = b_rvalid_r;
    assign bus.rdata    = rdata_r;

    // Round-robin pointer: hand priority to the other side after each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_b_r <= 1'b0;
        end else if (grant_a_s) begin
            rr_b_r <= 1'b1;
        end else if (grant_b_s) begin
            rr_b_r <= 1'b0;
        end
    end

    // BRAM issue register: one enabled cycle per accepted request or clear step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cen  <= 1'b1;
            mem_gwen <= 1'b0;
            mem_wen  <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else if (clr_issue_s) begin
            mem_cen  <= 1'b0;
            mem_gwen <= 1'b1;
            mem_wen  <= {LANES{1'b1}};
            mem_addr <= clr_addr_s;
            mem_din  <= clr_data_s;
        end else if (grant_a_s) begin
            mem_cen  <= 1'b0;
            mem_gwen <= bus.a_we;
            mem_wen  <= bus.a_we ? bus.a_wen : {LANES{1'b0}};
            mem_addr <= bus.a_addr;
            mem_din  <= bus.a_wdata;
        end else if (grant_b_s) begin
            mem_cen  <= 1'b0;
            mem_gwen <= 1'b0;
            mem_wen  <= '0;
            mem_addr <= bus.b_addr;
        end else begin
            mem_cen  <= 1'b1;
            mem_wen  <= '0;
        end
    end

    // Read-return pipeline: tag at accept, BRAM samples next edge, capture dout after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a_p1_r  <= 1'b0;
            rd_b_p1_r  <= 1'b0;
            rd_a_p2_r  <= 1'b0;
            rd_b_p2_r  <= 1'b0;
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
            rdata_r    <= '0;
        end else begin
            rd_a_p1_r  <= grant_a_s && !bus.a_we;
            rd_b_p1_r  <= grant_b_s;
            rd_a_p2_r  <= rd_a_p1_r;
            rd_b_p2_r  <= rd_b_p1_r;
            a_rvalid_r <= rd_a_p2_r;
            b_rvalid_r <= rd_b_p2_r;
            if (rd_a_p2_r || rd_b_p2_r) begin
                rdata_r <= mem_dout;
            end
        end
    end
endmodule

// File: tb/tb_bram_mask_arbiter.sv
// Self-checking bench for bram_mask_arbiter: behavioural lane-masked BRAM,
// plus a transaction-level reference (flat memory array, priority bit and a
// queue of expected read returns) compared against the DUT every cycle.
module tb_bram_mask_arbiter;
    localparam int AW    = 12;
    localparam int DW    = 24;
    localparam int MW    = 8;
    localparam int LANES = DW / MW;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr_start;
    logic [DW-1:0]    clr_value;
    logic             clr_busy, clr_done, mem_cen, mem_gwen;
    logic [LANES-1:0] mem_wen;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_din, mem_dout;
    logic             preload;

    always #5 clk = ~clk;

    bram_mask_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

    bram_mask_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .clr_start(clr_start), .clr_value(clr_value),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_cen(mem_cen), .mem_gwen(mem_gwen), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Reference state (transaction level)
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW-1:0] bram    [0:DEPTH-1];
    bit            ref_ptr_b;
    bit            m_clearing;
    int            m_clr_next;
    logic [DW-1:0] m_clr_val;
    typedef struct { int due; bit is_b; logic [DW-1:0] data; } ret_t;
    ret_t          ret_q[$];
    int            cyc, checks, errors;

    bit               obs_a_ready, obs_b_ready, exp_a_ready, exp_b_ready;
    bit               exp_cen, exp_gwen, exp_a_rv, exp_b_rv, exp_busy, exp_done;
    logic [LANES-1:0] exp_wen;
    logic [AW-1:0]    exp_addr;
    logic [DW-1:0]    exp_din, exp_rdata;

    // Behavioural BRAM: registered dout, lane-masked writes
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) bram[i] <= ref_mem[i];
        end else if (!mem_cen) begin
            if (mem_gwen) begin
                for (int l = 0; l < LANES; l++)
                    if (mem_wen[l]) bram[mem_addr][l*MW +: MW] <= mem_din[l*MW +: MW];
            end else begin
                mem_dout <= bram[mem_addr];
            end
        end
    end

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                                 input logic [LANES-1:0] wen);
        logic [DW-1:0] m;
        m = '0;
        for (int l = 0; l < LANES; l++) if (wen[l]) m[l*MW +: MW] = {MW{1'b1}};
        return (old_v & ~m) | (new_v & m);
    endfunction

    task automatic model_reset();
        ret_q.delete();
        ref_ptr_b  = 1'b0;
        m_clearing = 1'b0;
        exp_rdata  = '0;
    endtask

    // One clock: drive at negedge, capture readies, predict, step, land on next negedge
    task automatic tick(input bit av, input bit awe, input logic [LANES-1:0] awen, input logic [AW-1:0] aaddr,
                        input logic [DW-1:0] awd, input bit bv, input logic [AW-1:0] baddr,
                        input bit cs, input logic [DW-1:0] cv);
        int   grant;
        bit   blocked, was_clearing;
        ret_t r;
        bus.a_valid = av; bus.a_we = awe; bus.a_wen = awen; bus.a_addr = aaddr; bus.a_wdata = awd;
        bus.b_valid = bv; bus.b_addr = baddr; clr_start = cs; clr_value = cv;
        #1;
        obs_a_ready  = bus.a_ready;
        obs_b_ready  = bus.b_ready;
        was_clearing = m_clearing;
`ifdef BRAM_MASK_ARB_CLEAR_EN
        blocked = m_clearing || cs;
`else
        blocked = 1'b0;
`endif
        if (blocked || (!av && !bv)) grant = 0;
        else if (av && bv)           grant = ref_ptr_b ? 2 : 1;
        else                         grant = av ? 1 : 2;
        exp_a_ready = (grant == 1);
        exp_b_ready = (grant == 2);
        if (grant != 0) ref_ptr_b = (grant == 1);
        exp_cen = 1'b1; exp_wen = '0; exp_gwen = 1'b0; exp_addr = '0; exp_din = '0; exp_done = 1'b0;
        if (was_clearing) begin
            exp_cen = 1'b0; exp_gwen = 1'b1; exp_wen = '1; exp_addr = AW'(m_clr_next); exp_din = m_clr_val;
            ref_mem[m_clr_next] = m_clr_val;
            if (m_clr_next == DEPTH - 1) begin m_clearing = 1'b0; exp_done = 1'b1; end
            m_clr_next++;
        end else if (grant == 1) begin
            exp_cen = 1'b0; exp_gwen = awe; exp_wen = awe ? awen : '0; exp_addr = aaddr; exp_din = awd;
            if (awe) ref_mem[aaddr] = lane_merge(ref_mem[aaddr], awd, awen);
            else     ret_q.push_back('{cyc + 3, 1'b0, ref_mem[aaddr]});
        end else if (grant == 2) begin
            exp_cen = 1'b0; exp_addr = baddr;
            ret_q.push_back('{cyc + 3, 1'b1, ref_mem[baddr]});
        end
`ifdef BRAM_MASK_ARB_CLEAR_EN
        if (!was_clearing && cs) begin m_clearing = 1'b1; m_clr_next = 0; m_clr_val = cv; end
`endif
        exp_busy = m_clearing;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        exp_a_rv = 1'b0; exp_b_rv = 1'b0;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            r = ret_q.pop_front();
            if (r.is_b) exp_b_rv = 1'b1; else exp_a_rv = 1'b1;
            exp_rdata = r.data;
        end
    endtask

    task automatic tick_idle();
        tick(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; preload = 1'b1; clr_start = 1'b0; clr_value = '0;
        bus.a_valid = 1'b1; bus.b_valid = 1'b1; bus.a_we = 1'b0; bus.a_wen = '0;
        bus.a_addr = '0; bus.a_wdata = '0; bus.b_addr = '0;
        @(posedge clk); @(negedge clk);
        preload = 1'b0;
        checks++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", {bus.a_ready, bus.b_ready}); end
        checks++; if ({mem_cen, mem_gwen, mem_wen} !== 5'b10000) begin errors++; $display("FAIL rst_ctrl got %b exp 10000", {mem_cen, mem_gwen, mem_wen}); end
        checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL rst_addr got %h exp 000", mem_addr); end
        checks++; if (mem_din !== 24'h000000) begin errors++; $display("FAIL rst_din got %h exp 0", mem_din); end
        checks++; if ({bus.a_rvalid, bus.b_rvalid, clr_busy, clr_done} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b exp 0000", {bus.a_rvalid, bus.b_rvalid, clr_busy, clr_done}); end
        checks++; if (bus.rdata !== 24'h000000) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rdata); end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        logic [DW-1:0] want [2];
        want[0] = 24'hABCDEF; want[1] = 24'hAB34EF;
        for (int p = 0; p < 2; p++) begin
            if (p == 0) tick(1'b1, 1'b1, 3'b111, 12'd5, 24'hABCDEF, 1'b0, '0, 1'b0, '0);
            else        tick(1'b1, 1'b1, 3'b010, 12'd5, 24'h123456, 1'b0, '0, 1'b0, '0);
            checks++; if (obs_a_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %b exp 1", obs_a_ready); end
            checks++; if ({mem_cen, mem_gwen, mem_wen, mem_addr, mem_din} !== {exp_cen, exp_gwen, exp_wen, exp_addr, exp_din})
                begin errors++; $display("FAIL wr_issue got %b/%b/%b/%h/%h", mem_cen, mem_gwen, mem_wen, mem_addr, mem_din); end
            tick(1'b1, 1'b0, 3'b000, 12'd5, '0, 1'b0, '0, 1'b0, '0);
            checks++; if ({obs_a_ready, mem_cen, mem_gwen, mem_addr} !== {1'b1, 1'b0, 1'b0, 12'd5})
                begin errors++; $display("FAIL rd_issue got rdy=%b cen=%b gwen=%b addr=%h", obs_a_ready, mem_cen, mem_gwen, mem_addr); end
            for (int k = 0; k < 4; k++) begin
                tick_idle();
                checks++; if (bus.a_rvalid !== (k == 1) || bus.b_rvalid !== 1'b0)
                    begin errors++; $display("FAIL wr_rd_rvalid k=%0d got a=%b b=%b exp a=%b b=0", k, bus.a_rvalid, bus.b_rvalid, k == 1); end
                if (k == 1) begin
                    checks++; if (bus.rdata !== want[p]) begin errors++; $display("FAIL wr_rd_data got %h exp %h", bus.rdata, want[p]); end
                end
            end
        end
    endtask

    task automatic test_arbitration();
        int na, nb;
        logic [1:0] want;
        rst_n = 1'b0; #1; model_reset(); @(negedge clk); rst_n = 1'b1; @(negedge clk);
        na = 0; nb = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, '0, AW'(i), '0, 1'b1, AW'(i + 100), 1'b0, '0);
            want = (i % 2 == 0) ? 2'b10 : 2'b01;
            checks++; if ({obs_a_ready, obs_b_ready} !== want) begin errors++; $display("FAIL arb_grant i=%0d got %b exp %b", i, {obs_a_ready, obs_b_ready}, want); end
            checks++; if (mem_cen !== 1'b0) begin errors++; $display("FAIL arb_cen i=%0d got %b exp 0", i, mem_cen); end
            na += int'(obs_a_ready); nb += int'(obs_b_ready);
        end
        checks++; if (na != 4 || nb != 4) begin errors++; $display("FAIL arb_count got a=%0d b=%0d exp 4/4", na, nb); end
        for (int k = 0; k < 3; k++) begin
            tick_idle();
            checks++; if ({bus.a_rvalid, bus.b_rvalid} !== {exp_a_rv, exp_b_rv}) begin errors++; $display("FAIL arb_drain got %b exp %b", {bus.a_rvalid, bus.b_rvalid}, {exp_a_rv, exp_b_rv}); end
            if (exp_a_rv || exp_b_rv) begin
                checks++; if (bus.rdata !== exp_rdata) begin errors++; $display("FAIL arb_data got %h exp %h", bus.rdata, exp_rdata); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [4];
        for (int i = 0; i < 4; i++) begin
            vals[i] = DW'(32'h111111 * (i + 1));
            tick(1'b1, 1'b1, 3'b111, AW'(i), vals[i], 1'b0, '0, 1'b0, '0);
        end
        for (int t = 0; t < 10; t++) begin
            if (t < 4) tick(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(t), 1'b0, '0);
            else       tick_idle();
            checks++; if (bus.b_rvalid !== (t >= 2 && t <= 5) || bus.a_rvalid !== 1'b0)
                begin errors++; $display("FAIL b2b_rvalid t=%0d got b=%b a=%b", t, bus.b_rvalid, bus.a_rvalid); end
            if (t >= 2 && t <= 5) begin
                checks++; if (bus.rdata !== vals[t-2]) begin errors++; $display("FAIL b2b_data t=%0d got %h exp %h", t, bus.rdata, vals[t-2]); end
            end
        end
    endtask

    task automatic test_random();
        bit av, bv, awe;
        logic [LANES-1:0] awen;
        logic [AW-1:0] aaddr, baddr;
        logic [DW-1:0] awd;
        av = 1'b0; bv = 1'b0; awe = 1'b0; awen = '0; aaddr = '0; baddr = '0; awd = '0;
        for (int t = 0; t < 303; t++) begin
            if (t >= 300) begin av = 1'b0; bv = 1'b0; end
            else begin
                if (!av || obs_a_ready) begin
                    av = 1'($urandom_range(0, 1)); awe = 1'($urandom_range(0, 1));
                    awen = LANES'($urandom); aaddr = AW'($urandom_range(0, 15)); awd = DW'($urandom);
                end
                if (!bv || obs_b_ready) begin
                    bv = 1'($urandom_range(0, 1)); baddr = AW'($urandom_range(0, 15));
                end
            end
            tick(av, awe, awen, aaddr, awd, bv, baddr, 1'b0, '0);
            checks++; if ({obs_a_ready, obs_b_ready} !== {exp_a_ready, exp_b_ready}) begin errors++; $display("FAIL rnd_ready t=%0d got %b exp %b", t, {obs_a_ready, obs_b_ready}, {exp_a_ready, exp_b_ready}); end
            checks++; if (mem_cen !== exp_cen) begin errors++; $display("FAIL rnd_cen t=%0d got %b exp %b", t, mem_cen, exp_cen); end
            if (!exp_cen) begin
                checks++; if ({mem_gwen, mem_wen, mem_addr} !== {exp_gwen, exp_wen, exp_addr}) begin errors++; $display("FAIL rnd_issue t=%0d got %b/%b/%h exp %b/%b/%h", t, mem_gwen, mem_wen, mem_addr, exp_gwen, exp_wen, exp_addr); end
            end
            checks++; if ({bus.a_rvalid, bus.b_rvalid} !== {exp_a_rv, exp_b_rv}) begin errors++; $display("FAIL rnd_rvalid t=%0d got %b exp %b", t, {bus.a_rvalid, bus.b_rvalid}, {exp_a_rv, exp_b_rv}); end
            if (exp_a_rv || exp_b_rv) begin
                checks++; if (bus.rdata !== exp_rdata) begin errors++; $display("FAIL rnd_data t=%0d got %h exp %h", t, bus.rdata, exp_rdata); end
            end
        end
    endtask

    task automatic test_clear();
`ifdef BRAM_MASK_ARB_CLEAR_EN
        int busy_cnt, done_cnt;
        bit finished;
        logic [AW-1:0] ra;
        tick(1'b1, 1'b1, 3'b111, 12'd7, 24'h5A5A5A, 1'b0, '0, 1'b0, '0);
        tick(1'b1, 1'b0, 3'b000, 12'd7, '0, 1'b0, '0, 1'b0, '0);
        tick(1'b1, 1'b0, 3'b000, 12'd9, '0, 1'b1, '0, 1'b1, 24'h000000);
        checks++; if ({obs_a_ready, obs_b_ready} !== 2'b00) begin errors++; $display("FAIL clr_start_beats got %b exp 00", {obs_a_ready, obs_b_ready}); end
        busy_cnt = int'(clr_busy); done_cnt = 0; finished = 1'b0;
        for (int t = 0; t < 4200 && !finished; t++) begin
            tick(1'b1, 1'b0, '0, AW'(t % 16), '0, 1'b1, AW'(t % 8), (t == 20), 24'hFFFFFF);
            checks++; if ({obs_a_ready, obs_b_ready} !== 2'b00) begin errors++; $display("FAIL clr_ready t=%0d got %b exp 00", t, {obs_a_ready, obs_b_ready}); end
            checks++; if (clr_busy !== exp_busy) begin errors++; $display("FAIL clr_busy t=%0d got %b exp %b", t, clr_busy, exp_busy); end
            checks++; if ({mem_cen, mem_gwen, mem_wen, mem_addr, mem_din} !== {1'b0, 1'b1, 3'b111, AW'(t), 24'h000000})
                begin errors++; $display("FAIL clr_issue t=%0d got %b/%b/%b/%h/%h", t, mem_cen, mem_gwen, mem_wen, mem_addr, mem_din); end
            checks++; if ({bus.a_rvalid, bus.b_rvalid} !== {exp_a_rv, exp_b_rv}) begin errors++; $display("FAIL clr_rvalid t=%0d got %b exp %b", t, {bus.a_rvalid, bus.b_rvalid}, {exp_a_rv, exp_b_rv}); end
            if (exp_a_rv) begin
                checks++; if (bus.rdata !== 24'h5A5A5A) begin errors++; $display("FAIL clr_prior_read got %h exp 5a5a5a", bus.rdata); end
            end
            busy_cnt += int'(clr_busy);
            if (clr_done) begin done_cnt++; finished = 1'b1; end
        end
        checks++; if (busy_cnt != 4096) begin errors++; $display("FAIL clr_busy_len got %0d exp 4096", busy_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL clr_done_seen got %0d exp 1", done_cnt); end
        tick_idle();
        checks++; if ({clr_done, clr_busy} !== 2'b00) begin errors++; $display("FAIL clr_done_pulse got %b exp 00", {clr_done, clr_busy}); end
        for (int k = 0; k < 6; k++) begin
            ra = AW'($urandom);
            tick(1'b1, 1'b0, '0, ra, '0, 1'b0, '0, 1'b0, '0);
            tick_idle(); tick_idle();
            checks++; if (bus.a_rvalid !== 1'b1 || bus.rdata !== 24'h000000) begin errors++; $display("FAIL clr_readback addr=%h got v=%b d=%h exp 1/0", ra, bus.a_rvalid, bus.rdata); end
        end
`else
        tick(1'b1, 1'b1, 3'b111, 12'd7, 24'h5A5A5A, 1'b0, '0, 1'b0, '0);
        tick(1'b1, 1'b0, 3'b000, 12'd7, '0, 1'b0, '0, 1'b1, 24'h000000);
        checks++; if (obs_a_ready !== 1'b1) begin errors++; $display("FAIL noclr_ready got %b exp 1", obs_a_ready); end
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 24'h000000);
            checks++; if ({clr_busy, clr_done} !== 2'b00) begin errors++; $display("FAIL noclr_flags k=%0d got %b exp 00", k, {clr_busy, clr_done}); end
            if (k == 1) begin
                checks++; if (bus.a_rvalid !== 1'b1 || bus.rdata !== 24'h5A5A5A) begin errors++; $display("FAIL noclr_data got v=%b d=%h exp 1/5a5a5a", bus.a_rvalid, bus.rdata); end
            end
        end
`endif
    endtask

    task automatic test_reset_midflight();
        tick(1'b0, 1'b0, '0, '0, '0, 1'b1, 12'd2, 1'b0, '0);
        checks++; if (obs_b_ready !== 1'b1) begin errors++; $display("FAIL mid_accept got %b exp 1", obs_b_ready); end
        tick_idle();
        rst_n = 1'b0; bus.a_valid = 1'b1; bus.b_valid = 1'b1;
        #1;
        checks++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin errors++; $display("FAIL mid_ready got %b exp 00", {bus.a_ready, bus.b_ready}); end
        checks++; if ({mem_cen, mem_gwen, mem_wen, mem_addr, mem_din} !== {5'b10000, 12'h000, 24'h000000})
            begin errors++; $display("FAIL mid_mem got %b/%b/%b/%h/%h", mem_cen, mem_gwen, mem_wen, mem_addr, mem_din); end
        checks++; if ({bus.a_rvalid, bus.b_rvalid, clr_busy, clr_done, bus.rdata} !== {4'b0000, 24'h000000})
            begin errors++; $display("FAIL mid_outs got %b %h", {bus.a_rvalid, bus.b_rvalid, clr_busy, clr_done}, bus.rdata); end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); @(negedge clk);
            checks++; if (bus.b_rvalid !== 1'b0) begin errors++; $display("FAIL mid_no_rvalid k=%0d got %b exp 0", k, bus.b_rvalid); end
        end
        bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tick_idle();
            checks++; if ({bus.a_rvalid, bus.b_rvalid} !== 2'b00) begin errors++; $display("FAIL mid_after got %b exp 00", {bus.a_rvalid, bus.b_rvalid}); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'($urandom);
        test_reset();
        test_write_read();
        test_arbitration();
        test_back_to_back();
        test_random();
        test_clear();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
